// File: rtl/cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cdb_arbiter                                              |
// | Description : Common data bus arbiter. The ALU and the load path each  |
// |               push into a small private FIFO. A round-robin arbiter    |
// |               pops one head per cycle into a registered broadcast.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module cdb_arbiter #(
   parameter int ROB_POS_W = 4,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clr,
   input  logic                 alu_valid,
   input  logic [ROB_POS_W:0]   alu_rob_pos,
   input  logic [DATA_W-1:0]    alu_val,
   input  logic                 alu_jump,
   input  logic [DATA_W-1:0]    alu_pc,
   output logic                 alu_full,
   input  logic                 lsb_valid,
   input  logic [ROB_POS_W:0]   lsb_rob_pos,
   input  logic [DATA_W-1:0]    lsb_val,
   output logic                 lsb_full,
   output logic                 cdb_valid,
   output logic                 cdb_src,
   output logic [ROB_POS_W:0]   cdb_rob_pos,
   output logic [DATA_W-1:0]    cdb_val,
   output logic                 cdb_jump,
   output logic [DATA_W-1:0]    cdb_pc,
   output logic                 overflow_err
);

   localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
   localparam int                 c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic               c_SRC_ALU = 1'b0;
   localparam logic               c_SRC_LSB = 1'b1;

   // ALU FIFO storage and bookkeeping
   logic [ROB_POS_W:0]  r_alu_tag  [DEPTH];
   logic [DATA_W-1:0]   r_alu_val  [DEPTH];
   logic                r_alu_jump [DEPTH];
   logic [DATA_W-1:0]   r_alu_pc   [DEPTH];
   logic [c_PTR_W-1:0]  r_alu_rd;
   logic [c_PTR_W-1:0]  r_alu_wr;
   logic [c_CNT_W-1:0]  r_alu_cnt;

   // Load FIFO storage and bookkeeping
   logic [ROB_POS_W:0]  r_lsb_tag  [DEPTH];
   logic [DATA_W-1:0]   r_lsb_val  [DEPTH];
   logic [c_PTR_W-1:0]  r_lsb_rd;
   logic [c_PTR_W-1:0]  r_lsb_wr;
   logic [c_CNT_W-1:0]  r_lsb_cnt;

   logic                r_last_grant;
   logic                r_ovf;
   logic                r_cdb_valid;
   logic                r_cdb_src;
   logic [ROB_POS_W:0]  r_cdb_rob_pos;
   logic [DATA_W-1:0]   r_cdb_val;
   logic                r_cdb_jump;
   logic [DATA_W-1:0]   r_cdb_pc;

   logic w_alu_ne;
   logic w_lsb_ne;
   logic w_gnt_alu;
   logic w_gnt_lsb;
   logic w_alu_push;
   logic w_lsb_push;
   logic w_push_drop;

   // Full flags depend only on registered counts, so a pop this cycle
   // never opens a slot for a push in the same cycle.
   assign alu_full = (r_alu_cnt == c_FULL);
   assign lsb_full = (r_lsb_cnt == c_FULL);

   assign w_alu_ne  = (r_alu_cnt != '0);
   assign w_lsb_ne  = (r_lsb_cnt != '0);

   // When both heads are waiting, the source that did not win last time goes.
   assign w_gnt_alu = w_alu_ne && (!w_lsb_ne || (r_last_grant == c_SRC_LSB));
   assign w_gnt_lsb = w_lsb_ne && (!w_alu_ne || (r_last_grant == c_SRC_ALU));

   assign w_alu_push  = alu_valid && !alu_full;
   assign w_lsb_push  = lsb_valid && !lsb_full;
   assign w_push_drop = (alu_valid && alu_full) || (lsb_valid && lsb_full);

   assign cdb_valid    = r_cdb_valid;
   assign cdb_src      = r_cdb_src;
   assign cdb_rob_pos  = r_cdb_rob_pos;
   assign cdb_val      = r_cdb_val;
   assign cdb_jump     = r_cdb_jump;
   assign cdb_pc       = r_cdb_pc;
   assign overflow_err = r_ovf;

   // FIFO payload writes; contents need no reset because counts gate reads.
   always_ff @(posedge clk) begin
      if (!rst && !clr && rdy) begin
         if (w_alu_push) begin
            r_alu_tag[r_alu_wr]  <= alu_rob_pos;
            r_alu_val[r_alu_wr]  <= alu_val;
            r_alu_jump[r_alu_wr] <= alu_jump;
            r_alu_pc[r_alu_wr]   <= alu_pc;
         end
         if (w_lsb_push) begin
            r_lsb_tag[r_lsb_wr] <= lsb_rob_pos;
            r_lsb_val[r_lsb_wr] <= lsb_val;
         end
      end
   end

   // Pointers, counts, round-robin state, sticky overflow and the bus register.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_alu_rd      <= '0;
         r_alu_wr      <= '0;
         r_alu_cnt     <= '0;
         r_lsb_rd      <= '0;
         r_lsb_wr      <= '0;
         r_lsb_cnt     <= '0;
         r_last_grant  <= c_SRC_LSB;
         r_cdb_valid   <= 1'b0;
         r_cdb_src     <= 1'b0;
         r_cdb_rob_pos <= '0;
         r_cdb_val     <= '0;
         r_cdb_jump    <= 1'b0;
         r_cdb_pc      <= '0;
         if (rst) begin
            r_ovf <= 1'b0;
         end
      end else if (rdy) begin
         if (w_alu_push) begin
            r_alu_wr <= r_alu_wr + c_PTR_ONE;
         end
         if (w_gnt_alu) begin
            r_alu_rd <= r_alu_rd + c_PTR_ONE;
         end
         r_alu_cnt <= r_alu_cnt + c_CNT_W'(w_alu_push) - c_CNT_W'(w_gnt_alu);

         if (w_lsb_push) begin
            r_lsb_wr <= r_lsb_wr + c_PTR_ONE;
         end
         if (w_gnt_lsb) begin
            r_lsb_rd <= r_lsb_rd + c_PTR_ONE;
         end
         r_lsb_cnt <= r_lsb_cnt + c_CNT_W'(w_lsb_push) - c_CNT_W'(w_gnt_lsb);

         if (w_push_drop) begin
            r_ovf <= 1'b1;
         end

         if (w_gnt_alu) begin
            r_cdb_valid   <= 1'b1;
            r_cdb_src     <= c_SRC_ALU;
            r_cdb_rob_pos <= r_alu_tag[r_alu_rd];
            r_cdb_val     <= r_alu_val[r_alu_rd];
            r_cdb_jump    <= r_alu_jump[r_alu_rd];
            r_cdb_pc      <= r_alu_pc[r_alu_rd];
            r_last_grant  <= c_SRC_ALU;
         end else if (w_gnt_lsb) begin
            r_cdb_valid   <= 1'b1;
            r_cdb_src     <= c_SRC_LSB;
            r_cdb_rob_pos <= r_lsb_tag[r_lsb_rd];
            r_cdb_val     <= r_lsb_val[r_lsb_rd];
            r_cdb_jump    <= 1'b0;
            r_cdb_pc      <= '0;
            r_last_grant  <= c_SRC_LSB;
         end else begin
            r_cdb_valid   <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cdb_arbiter                                           |
// | Description : Scoreboard bench for cdb_arbiter. A queue-based model of |
// |               both FIFOs and the round-robin choice produces one       |
// |               expected bus/flag snapshot per clock edge.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, rdy, clr;
   logic        alu_valid;
   logic [4:0]  alu_rob_pos;
   logic [31:0] alu_val;
   logic        alu_jump;
   logic [31:0] alu_pc;
   logic        alu_full;
   logic        lsb_valid;
   logic [4:0]  lsb_rob_pos;
   logic [31:0] lsb_val;
   logic        lsb_full;
   logic        cdb_valid, cdb_src;
   logic [4:0]  cdb_rob_pos;
   logic [31:0] cdb_val;
   logic        cdb_jump;
   logic [31:0] cdb_pc;
   logic        overflow_err;

   always #5 clk = ~clk;

   cdb_arbiter #(.ROB_POS_W(4), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
      .alu_jump(alu_jump), .alu_pc(alu_pc), .alu_full(alu_full),
      .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
      .lsb_full(lsb_full),
      .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_pos(cdb_rob_pos),
      .cdb_val(cdb_val), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc),
      .overflow_err(overflow_err)
   );

   typedef struct packed {
      logic [4:0]  pos;
      logic [31:0] val;
      logic        jump;
      logic [31:0] pc;
   } ent_t;

   typedef struct packed {
      logic        v;
      logic        src;
      logic [4:0]  pos;
      logic [31:0] val;
      logic        jump;
      logic [31:0] pc;
      logic        af;
      logic        lf;
      logic        ovf;
   } snap_t;

   ent_t  m_alu[$];
   ent_t  m_lsb[$];
   logic  m_last = 1'b1;
   logic  m_ovf  = 1'b0;
   snap_t m_bus  = '0;
   snap_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   // Drive one cycle, advance the model across the edge, queue the expected snapshot.
   task automatic cyc(input logic r, input logic c, input logic y,
                      input logic av, input logic [4:0] ap, input logic [31:0] aval,
                      input logic aj, input logic [31:0] apc,
                      input logic lv, input logic [4:0] lp, input logic [31:0] lval);
      ent_t e;
      logic a_full, l_full, ga, gl;
      rst = r; clr = c; rdy = y;
      alu_valid = av; alu_rob_pos = ap; alu_val = aval; alu_jump = aj; alu_pc = apc;
      lsb_valid = lv; lsb_rob_pos = lp; lsb_val = lval;
      @(posedge clk);
      if (r || c) begin
         m_alu.delete();
         m_lsb.delete();
         m_last = 1'b1;
         if (r) m_ovf = 1'b0;
         m_bus = '0;
      end else if (y) begin
         a_full = (m_alu.size() == DEPTH);
         l_full = (m_lsb.size() == DEPTH);
         ga = (m_alu.size() != 0) && ((m_lsb.size() == 0) || m_last);
         gl = (m_lsb.size() != 0) && !ga;
         m_bus.v = ga || gl;
         if (ga) begin
            e = m_alu.pop_front();
            m_bus.src = 1'b0; m_bus.pos = e.pos; m_bus.val = e.val;
            m_bus.jump = e.jump; m_bus.pc = e.pc;
            m_last = 1'b0;
         end else if (gl) begin
            e = m_lsb.pop_front();
            m_bus.src = 1'b1; m_bus.pos = e.pos; m_bus.val = e.val;
            m_bus.jump = 1'b0; m_bus.pc = 32'h0;
            m_last = 1'b1;
         end
         if (av) begin
            if (a_full) m_ovf = 1'b1;
            else m_alu.push_back(ent_t'({ap, aval, aj, apc}));
         end
         if (lv) begin
            if (l_full) m_ovf = 1'b1;
            else m_lsb.push_back(ent_t'({lp, lval, 1'b0, 32'h0}));
         end
      end
      m_bus.af  = (m_alu.size() == DEPTH);
      m_bus.lf  = (m_lsb.size() == DEPTH);
      m_bus.ovf = m_ovf;
      exp_q.push_back(m_bus);
      #1;
   endtask

   task automatic idle(input logic r, input logic c, input logic y);
      cyc(r, c, y, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0);
   endtask

   function automatic snap_t observe();
      return {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc,
              alu_full, lsb_full, overflow_err};
   endfunction

   task automatic test_reset();
      snap_t e, o;
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'h1f, 32'hdead, 1'b1, 32'hbeef, 1'b1, 5'h1e, 32'hcafe);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_snapshot: got %h want %h", o, e);
      end
      n_cmp++;
      if (o !== snap_t'(0)) begin
         n_fail++;
         $display("FAIL reset_all_zero: got %h want 0", o);
      end
   endtask

   task automatic test_single_alu();
      snap_t e, o;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i == 1) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'h13, 32'h1234, 1'b1, 32'h80,
                              1'b0, 5'h0, 32'h0);
         else idle(1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL single_alu step %0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_tie();
      snap_t e, o;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i == 1) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'h11, 32'ha1, 1'b1, 32'h40,
                              1'b1, 5'h12, 32'hb2);
         else idle(1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL tie step %0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_continuous();
      snap_t e, o;
      logic  av, lv;
      logic [4:0] at, lt;
      at = 5'h00;
      lt = 5'h10;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i <= 8) begin
            av = (m_alu.size() < DEPTH);
            lv = (m_lsb.size() < DEPTH);
            cyc(1'b0, 1'b0, 1'b1, av, at, 32'h100 + 32'(at), at[0], 32'h2000 + 32'(at),
                lv, lt, 32'h300 + 32'(lt));
            if (av) at = at + 5'h1;
            if (lv) lt = lt + 5'h1;
         end else idle(1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL continuous step %0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_fill();
      snap_t e, o;
      for (int i = 0; i < 9; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i <= 3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'(i), 32'h500 + 32'(i), 1'b0, 32'h0,
                              1'b1, 5'h10 + 5'(i), 32'h600 + 32'(i));
         else if (i == 7) idle(1'b0, 1'b1, 1'b1);
         else idle(1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL fill step %0d: got %h want %h", i, o, e);
         end
      end
      n_cmp++;
      if (overflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky_after_clr: got %b want 1", overflow_err);
      end
   endtask

   task automatic test_clr();
      snap_t e, o;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i <= 2) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'h18 + 5'(i), 32'h700 + 32'(i), 1'b1,
                              32'h900, 1'b1, 5'h08 + 5'(i), 32'h800 + 32'(i));
         else if (i == 3) cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'h1d, 32'h777, 1'b1, 32'h990,
                              1'b0, 5'h0, 32'h0);
         else idle(1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL clr step %0d: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_stall_and_rst();
      snap_t e, o;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) idle(1'b1, 1'b0, 1'b1);
         else if (i == 1) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'h14, 32'haaa, 1'b0, 32'h0,
                              1'b1, 5'h15, 32'hbbb);
         else if (i == 2) idle(1'b0, 1'b0, 1'b1);
         else if (i <= 5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'h1a, 32'hccc, 1'b1, 32'hddd,
                              1'b1, 5'h1b, 32'heee);
         else if (i <= 7) idle(1'b0, 1'b0, 1'b1);
         else if (i <= 10) cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'h02 + 5'(i), 32'h40 + 32'(i), 1'b1,
                               32'h50, 1'b1, 5'h06 + 5'(i), 32'h60 + 32'(i));
         else cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'h1f, 32'h1, 1'b1, 32'h2, 1'b1, 5'h1e, 32'h3);
         e = exp_q.pop_front();
         o = observe();
         n_cmp++;
         if (o.v !== e.v || {o.af, o.lf, o.ovf} !== {e.af, e.lf, e.ovf} || (e.v && o !== e)) begin
            n_fail++;
            $display("FAIL stall step %0d: got %h want %h", i, o, e);
         end
      end
      o = observe();
      n_cmp++;
      if (o !== snap_t'(0)) begin
         n_fail++;
         $display("FAIL midstream_rst_zero: got %h want 0", o);
      end
   endtask

   initial begin
      test_reset();
      test_single_alu();
      test_tie();
      test_continuous();
      test_fill();
      test_clr();
      test_stall_and_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
